// File: rtl/nss_pkg.sv
// rtl/nss_pkg.sv - shared constants, state codes and helpers for the nibble-serial subtractor
// Contents: NIB_W (nibble width), FSM state codes ST_IDLE/ST_RUN/ST_DONE,
//           signed_ovf() for the subtraction overflow flag.
package nss_pkg;

    localparam int NIB_W = 4;

    // State codes kept as plain constants so the encoding stays fixed across tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Overflow of A - B: operands of opposite sign and the result sign differs from A.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - operand/result handshake bundle
// Signals: in_valid/in_ready + A, B, Bin (operand side);
//          out_valid/out_ready + D, Bout, Z, V (result side).
// Modports: master = producer/consumer around the block, slave = the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Z;
    logic             V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, Z, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, Z, V
    );
endinterface

// File: rtl/nibble_bla_sub.sv
// rtl/nibble_bla_sub.sv - combinational 4-bit borrow-lookahead subtractor
// Ports: a, b (4-bit operands), bin (borrow in) -> d (a - b - bin),
//        bout (borrow out), PG/GG (group borrow propagate/generate).
module nibble_bla_sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout,
    output logic       PG,
    output logic       GG
);
    logic [3:0] gb;
    logic [3:0] pb;
    logic [3:0] bw;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign gb = ~a & b;
    assign pb = ~(a ^ b);

    assign bw[0] = bin;
    assign bw[1] = gb[0] | (pb[0] & bin);
    assign bw[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & bin);
    assign bw[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & bin);

    assign GG   = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign PG   = &pb;
    assign bout = GG | (PG & bin);

    assign d = a ^ b ^ bw;
endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - D = A - B - Bin computed one nibble per clock, LSB first
// Ports: clk, rst_n (async, active low), bus (slave side of nibble_serial_subtractor_if).
module nibble_serial_subtractor
    import nss_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_serial_subtractor_if.slave    bus
);
    localparam int N  = WIDTH / NIB_W;
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             z_q, z_d;
    logic             v_q, v_d;

    logic [NIB_W-1:0] nib_d;
    logic             nib_bout;
    logic             nib_pg;
    logic             nib_gg;
    logic             unused_group;

    nibble_bla_sub u_nib (
        .a    (a_q[k_q*NIB_W +: NIB_W]),
        .b    (b_q[k_q*NIB_W +: NIB_W]),
        .bin  (borrow_q),
        .d    (nib_d),
        .bout (nib_bout),
        .PG   (nib_pg),
        .GG   (nib_gg)
    );

    // Group terms are only needed by a parallel variant; the serial chain uses bout.
    assign unused_group = nib_pg ^ nib_gg;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        z_d      = z_q;
        v_d      = v_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d  = ST_RUN;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.Bin;
                    k_d      = '0;
                end
            end
            ST_RUN: begin
                d_d[k_q*NIB_W +: NIB_W] = nib_d;
                borrow_d = nib_bout;
                k_d      = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // Flags are taken from the fully assembled difference.
                    state_d = ST_DONE;
                    k_d     = '0;
                    bout_d  = nib_bout;
                    z_d     = (d_d == '0);
                    v_d     = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], d_d[WIDTH-1]);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.Z         = z_q;
    assign bus.V         = v_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for D/Bout, signed range for V.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic z, output logic v);
        int diff;
        int sdiff;
        diff  = int'(a) - int'(b) - int'(bin);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d     = diff[W-1:0];
        bo    = (diff < 0);
        z     = (d == '0);
        v     = (sdiff > 32767) || (sdiff < -32768);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check_val("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Present operands at a negedge, count clocks to out_valid, check result,
    // optionally stall out_ready for 'hold' cycles, then complete the handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int hold);
        logic [W-1:0] ed;
        logic eb, ez, ev;
        int lat;
        wait_ready();
        model(a, b, bin, ed, eb, ez, ev);
        bus.A = a; bus.B = b; bus.Bin = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.Bin = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check_val("latency", 32'(lat), 32'd4);
        check_val("D", 32'(bus.D), 32'(ed));
        check_val("Bout", 32'(bus.Bout), 32'(eb));
        check_val("Z", 32'(bus.Z), 32'(ez));
        check_val("V", 32'(bus.V), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_D", 32'(bus.D), 32'(ed));
            check_val("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("post_hs_valid", 32'(bus.out_valid), 32'd0);
        check_val("post_hs_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    logic [W-1:0] vec_a   [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555, 16'h0010, 16'hFFFF};
    logic [W-1:0] vec_b   [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h5555, 16'h000F, 16'h0001};
    logic         vec_bin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [W-1:0] held_d;
        logic [W-1:0] ed;
        logic eb, ez, ev;
        n_checks = 0;
        n_errors = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_D", 32'(bus.D), 32'd0);
        check_val("rst_flags", 32'({bus.Bout, bus.Z, bus.V}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 6; i++) do_op(vec_a[i], vec_b[i], vec_bin[i], 0);

        // Stall the consumer while new operands and in_valid toggles are presented
        wait_ready();
        bus.A = 16'h0F00; bus.B = 16'h0123; bus.Bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        held_d = bus.D;
        check_val("stall_first_D", 32'(held_d), 32'h0DDD);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.A = W'($urandom); bus.B = W'($urandom); bus.Bin = 1'($urandom);
            @(negedge clk);
            check_val("stall_D", 32'(bus.D), 32'(held_d));
            check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("release_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        do_op(16'hABCD, 16'h1234, 1'b1, 0);

        // Reset in the middle of RUN, with a live borrow in flight
        wait_ready();
        bus.A = 16'h0000; bus.B = 16'h0001; bus.Bin = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrun_rst_ready", 32'(bus.in_ready), 32'd1);
        check_val("midrun_rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrun_rst_D", 32'(bus.D), 32'd0);
        check_val("midrun_rst_flags", 32'({bus.Bout, bus.Z, bus.V}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);

        // Randomized operands with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Flag-only sanity against the model for a corner pair
        model(16'h7FFF, 16'hFFFF, 1'b1, ed, eb, ez, ev);
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
